// File: rtl/small_fsm_debounce_filter.sv
// Debounce filter: synchronizer chain + 4-state stability FSM producing a clean level and rise/fall strobes.
// Optional rejected-glitch counter is built when DEBOUNCE_GLITCH_CNT_EN is defined.
module small_fsm_debounce_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CNT  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_in,
   input  logic       en,
`ifdef DEBOUNCE_GLITCH_CNT_EN
   input  logic       glitch_clr,
   output logic [7:0] glitch_cnt,
`endif
   output logic       clean_out,
   output logic       rise_pulse,
   output logic       fall_pulse
);

   localparam int CNT_W = $clog2(STABLE_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   typedef enum logic [1:0] {LOW, LOW2HIGH, HIGH, HIGH2LOW} state_t;

   logic [SYNC_STAGES-1:0] sync_chain_q;
   logic                   sync_q;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   glitch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_chain_q <= '0;
      else     sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], raw_in};
   end

   assign sync_q = sync_chain_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOW;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      glitch  = 1'b0;
      if (en) begin
         case (state_q)
            LOW: begin
               if (sync_q) begin
                  if (STABLE_CNT == 1) state_d = HIGH;
                  else begin
                     state_d = LOW2HIGH;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            LOW2HIGH: begin
               if (!sync_q) begin
                  state_d = LOW;
                  cnt_d   = '0;
                  glitch  = 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = HIGH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            HIGH: begin
               if (!sync_q) begin
                  if (STABLE_CNT == 1) state_d = LOW;
                  else begin
                     state_d = HIGH2LOW;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            HIGH2LOW: begin
               if (sync_q) begin
                  state_d = HIGH;
                  cnt_d   = '0;
                  glitch  = 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = LOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = LOW;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // A rejected candidate returns to its old level, so only real level changes strobe.
   assign clean_d = (state_d == HIGH) || (state_d == HIGH2LOW);
   assign rise_d  = (state_d == HIGH) && ((state_q == LOW) || (state_q == LOW2HIGH));
   assign fall_d  = (state_d == LOW) && ((state_q == HIGH) || (state_q == HIGH2LOW));

   assign clean_out  = clean_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               glitch_cnt_q <= '0;
      else if (glitch_clr)                   glitch_cnt_q <= '0;
      else if (glitch && glitch_cnt_q != 8'hFF) glitch_cnt_q <= glitch_cnt_q + 8'd1;
   end

   assign glitch_cnt = glitch_cnt_q;
`else
   logic unused_glitch;
   assign unused_glitch = glitch;
`endif

endmodule

// File: tb/tb_small_fsm_debounce_filter.sv
// Directed bench for small_fsm_debounce_filter at defaults (SYNC_STAGES=2, STABLE_CNT=4).
// Glitch-counter scenarios are included when DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_small_fsm_debounce_filter;

   logic clk = 1'b0;
   logic rst, raw_in, en;
   logic clean_out, rise_pulse, fall_pulse;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic       glitch_clr;
   logic [7:0] glitch_cnt;
`endif

   int errors = 0;
   int checks = 0;

   small_fsm_debounce_filter #(.SYNC_STAGES(2), .STABLE_CNT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (raw_in),
      .en         (en),
`ifdef DEBOUNCE_GLITCH_CNT_EN
      .glitch_clr (glitch_clr),
      .glitch_cnt (glitch_cnt),
`endif
      .clean_out  (clean_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [2:0] exp_v;
      rst = 1'b1; raw_in = 1'b0; en = 1'b1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      glitch_clr = 1'b0;
`endif
      step(); step();
      checks++;
      if ({clean_out, rise_pulse, fall_pulse} !== 3'b000) begin
         errors++;
         $display("FAIL reset_state: got %b expected 000", {clean_out, rise_pulse, fall_pulse});
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      checks++;
      if (glitch_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_glitch_cnt: got %0d expected 0", glitch_cnt);
      end
`endif
      rst = 1'b0;
      exp_v = 3'b000;
      for (int j = 1; j <= 20; j++) begin
         step();
         checks++;
         if ({clean_out, rise_pulse, fall_pulse} !== exp_v) begin
            errors++;
            $display("FAIL idle_low cyc=%0d: got %b expected %b", j, {clean_out, rise_pulse, fall_pulse}, exp_v);
         end
      end
   endtask

   task automatic test_rise();
      logic [2:0] exp_v;
      raw_in = 1'b1;
      for (int j = 1; j <= 9; j++) begin
         step();
         exp_v = {j >= 6, j == 6, 1'b0};
         checks++;
         if ({clean_out, rise_pulse, fall_pulse} !== exp_v) begin
            errors++;
            $display("FAIL rise cyc=%0d: got %b expected %b", j, {clean_out, rise_pulse, fall_pulse}, exp_v);
         end
      end
   endtask

   // Only even-numbered edges are enabled: the 4th enabled sample is edge 10.
   task automatic test_fall_en_gated();
      logic [2:0] exp_v;
      raw_in = 1'b0;
      for (int j = 1; j <= 13; j++) begin
         en = (j % 2 == 0);
         step();
         exp_v = {j < 10, 1'b0, j == 10};
         checks++;
         if ({clean_out, rise_pulse, fall_pulse} !== exp_v) begin
            errors++;
            $display("FAIL fall_en cyc=%0d: got %b expected %b", j, {clean_out, rise_pulse, fall_pulse}, exp_v);
         end
      end
      en = 1'b1;
   endtask

   task automatic test_glitch();
      logic [2:0] exp_v;
      exp_v = 3'b000;
      for (int j = 1; j <= 12; j++) begin
         raw_in = (j <= 3);
         step();
         checks++;
         if ({clean_out, rise_pulse, fall_pulse} !== exp_v) begin
            errors++;
            $display("FAIL glitch cyc=%0d: got %b expected %b", j, {clean_out, rise_pulse, fall_pulse}, exp_v);
         end
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      checks++;
      if (glitch_cnt !== 8'd1) begin
         errors++;
         $display("FAIL glitch_cnt_one: got %0d expected 1", glitch_cnt);
      end
`endif
   endtask

   // Exactly STABLE_CNT samples high is the shortest accepted pulse.
   task automatic test_min_pulse();
      logic [2:0] exp_v;
      for (int j = 1; j <= 13; j++) begin
         raw_in = (j <= 4);
         step();
         exp_v = {(j >= 6) && (j < 10), j == 6, j == 10};
         checks++;
         if ({clean_out, rise_pulse, fall_pulse} !== exp_v) begin
            errors++;
            $display("FAIL min_pulse cyc=%0d: got %b expected %b", j, {clean_out, rise_pulse, fall_pulse}, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid_check();
      logic [2:0] exp_v;
      raw_in = 1'b1;
      repeat (4) step();
      rst = 1'b1;
      #1;
      checks++;
      if ({clean_out, rise_pulse, fall_pulse} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid: got %b expected 000", {clean_out, rise_pulse, fall_pulse});
      end
      step();
      rst = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         step();
         exp_v = {j >= 6, j == 6, 1'b0};
         checks++;
         if ({clean_out, rise_pulse, fall_pulse} !== exp_v) begin
            errors++;
            $display("FAIL reset_release cyc=%0d: got %b expected %b", j, {clean_out, rise_pulse, fall_pulse}, exp_v);
         end
      end
   endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
   task automatic do_glitch(input logic clr_on_inc);
      raw_in = 1'b1;
      repeat (3) step();
      raw_in = 1'b0;
      repeat (2) step();
      glitch_clr = clr_on_inc;
      step();
      glitch_clr = 1'b0;
   endtask

   task automatic test_glitch_saturate();
      raw_in = 1'b0;
      repeat (8) step();
      glitch_clr = 1'b1;
      step();
      glitch_clr = 1'b0;
      for (int i = 0; i < 254; i++) do_glitch(1'b0);
      checks++;
      if (glitch_cnt !== 8'd254) begin
         errors++;
         $display("FAIL glitch_cnt_254: got %0d expected 254", glitch_cnt);
      end
      for (int i = 0; i < 46; i++) do_glitch(1'b0);
      checks++;
      if (glitch_cnt !== 8'd255) begin
         errors++;
         $display("FAIL glitch_cnt_sat: got %0d expected 255", glitch_cnt);
      end
      do_glitch(1'b1);
      checks++;
      if (glitch_cnt !== 8'd0) begin
         errors++;
         $display("FAIL glitch_clr_wins: got %0d expected 0", glitch_cnt);
      end
      do_glitch(1'b0);
      checks++;
      if (glitch_cnt !== 8'd1) begin
         errors++;
         $display("FAIL glitch_after_clr: got %0d expected 1", glitch_cnt);
      end
      checks++;
      if (clean_out !== 1'b0) begin
         errors++;
         $display("FAIL glitch_level: got %b expected 0", clean_out);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_rise();
      test_fall_en_gated();
      test_glitch();
      test_min_pulse();
      test_reset_mid_check();
`ifdef DEBOUNCE_GLITCH_CNT_EN
      test_glitch_saturate();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
